dma_tx_demux: RTL and testbench

- Parametrised successor of the fixed 8-way DMA TX splitter. Takes one AXI-stream from the DMA engine and distributes fixed-length bursts round-robin to NCH downstream channel buffers (data/coefficient RAM loaders).
- Adds an explicit beat counter, a per-frame channel-enable mask, per-channel buffer-busy stalls, tlast checking and frame-done/error status.

---
 rtl/dma_tx_pkg.sv | 33 +++
 rtl/dma_rr_ptr.sv | 32 +++
 rtl/dma_tx_demux.sv | 146 ++++++++++++++
 tb/tb_dma_tx_demux.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_tx_pkg.sv
// Shared types and helpers for the DMA TX demux and its sibling RX collector.
// The channel-search helper is sized for the largest supported channel count.
package dma_tx_pkg;

    localparam int MAX_NCH = 16;
    localparam int MAX_IW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_e;

    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } en_idx_t;

    // Lowest set bit of mask strictly above ptr; found is clear if there is none.
    function automatic en_idx_t next_en_idx(input logic [MAX_NCH-1:0] mask,
                                            input logic [MAX_IW-1:0]  ptr);
        en_idx_t r;
        r = '0;
        for (int i = MAX_NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ptr))) begin
                r.found = 1'b1;
                r.idx   = MAX_IW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_rr_ptr.sv
// Combinational next-enabled-channel finder over a channel mask.
// With incl set, ptr itself is a candidate (used to find the first channel).
module dma_rr_ptr
    import dma_tx_pkg::*;
#(
    parameter int NCH = 8,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [IW-1:0]  ptr,
    input  logic           incl,
    output logic           found,
    output logic [IW-1:0]  idx
);

    logic [MAX_NCH-1:0] mask_ext;
    en_idx_t            nxt;

    // NOTE: every output gets a value before any condition, so no latch is inferred.
    always_comb begin
        mask_ext           = '0;
        mask_ext[NCH-1:0]  = mask;
        nxt                = next_en_idx(mask_ext, MAX_IW'(ptr));
        found              = nxt.found;
        idx                = IW'(nxt.idx);
        if (incl && mask[ptr]) begin
            found = 1'b1;
            idx   = ptr;
        end
    end

endmodule

// File: rtl/dma_tx_demux.sv
// Splits one DMA AXI-stream into fixed-length bursts, round-robin over the
// channels enabled at frame start, with per-channel busy stalls and tlast checking.
module dma_tx_demux
    import dma_tx_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int DW        = 64,
    parameter int BURST_LEN = 256,
    parameter int CW        = $clog2(BURST_LEN),
    parameter int IW        = $clog2(NCH)
) (
    input  logic              clk_dma,
    input  logic              srstn,
    output logic              s_axi_dma_trdy,
    input  logic              s_axi_dma_tvld,
    input  logic [DW-1:0]     s_axi_dma_tdat,
    input  logic              s_axi_dma_tlst,
    input  logic [NCH-1:0]    m_axi_trdy,
    output logic [NCH-1:0]    m_axi_tvld,
    output logic [NCH*DW-1:0] m_axi_tdat,
    output logic [NCH-1:0]    m_axi_tlst,
    input  logic [NCH-1:0]    ch_ram_rdy,
    input  logic [NCH-1:0]    ch_en,
    output logic [IW-1:0]     cur_ch,
    output logic              busy,
    output logic              frame_done,
    output logic              err_tlst
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    state_e         state_q, state_d;
    logic [NCH-1:0] sel_q, sel_d;
    logic [NCH-1:0] en_q, en_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  cur_ch_q, cur_ch_d;
    logic           frame_done_q, frame_done_d;
    logic           err_tlst_q, err_tlst_d;

    logic           first_found, next_found;
    logic [IW-1:0]  first_idx, next_idx;
    logic           beat_acc, last_beat, final_beat;

    dma_rr_ptr #(.NCH(NCH), .IW(IW)) u_first (
        .mask  (ch_en),
        .ptr   ({IW{1'b0}}),
        .incl  (1'b1),
        .found (first_found),
        .idx   (first_idx)
    );

    dma_rr_ptr #(.NCH(NCH), .IW(IW)) u_next (
        .mask  (en_q),
        .ptr   (ptr_q),
        .incl  (1'b0),
        .found (next_found),
        .idx   (next_idx)
    );

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_dma) begin
        if (!srstn) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            en_q         <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            cur_ch_q     <= '0;
            frame_done_q <= 1'b0;
            err_tlst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            cur_ch_q     <= cur_ch_d;
            frame_done_q <= frame_done_d;
            err_tlst_q   <= err_tlst_d;
        end
    end

    always_comb begin
        beat_acc     = s_axi_dma_tvld & s_axi_dma_trdy;
        last_beat    = beat_acc & (cnt_q == LAST_BEAT);
        final_beat   = last_beat & ~next_found;

        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        cur_ch_d     = cur_ch_q;
        frame_done_d = 1'b0;
        // The beat counter, not upstream tlast, decides burst and frame boundaries.
        err_tlst_d   = beat_acc & (s_axi_dma_tlst ^ final_beat);

        case (state_q)
            IDLE: begin
                if (first_found) begin
                    en_d    = ch_en;
                    ptr_d   = first_idx;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!ch_ram_rdy[ptr_q]) begin
                    sel_d    = NCH'(1) << ptr_q;
                    cur_ch_d = ptr_q;
                    cnt_d    = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (last_beat) begin
                    sel_d = '0;
                    cnt_d = '0;
                    if (next_found) begin
                        ptr_d   = next_idx;
                        state_d = WAIT;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axi_dma_trdy = |(sel_q & m_axi_trdy);
        m_axi_tvld     = sel_q & {NCH{s_axi_dma_tvld}};
        m_axi_tdat     = {NCH{s_axi_dma_tdat}};
        m_axi_tlst     = sel_q & {NCH{cnt_q == LAST_BEAT}};
        busy           = (state_q != IDLE);
        cur_ch         = cur_ch_q;
        frame_done     = frame_done_q;
        err_tlst       = err_tlst_q;
    end

endmodule

// File: tb/tb_dma_tx_demux.sv
// Randomised self-checking bench for dma_tx_demux (4 channels, 4-beat bursts).
// Expected routing is rebuilt per frame from the enable mask and the source data list.
module tb_dma_tx_demux;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int BL  = 4;
    localparam int IW  = 2;

    logic              clk_dma = 1'b0;
    logic              srstn;
    logic              s_axi_dma_trdy;
    logic              s_axi_dma_tvld;
    logic [DW-1:0]     s_axi_dma_tdat;
    logic              s_axi_dma_tlst;
    logic [NCH-1:0]    m_axi_trdy;
    logic [NCH-1:0]    m_axi_tvld;
    logic [NCH*DW-1:0] m_axi_tdat;
    logic [NCH-1:0]    m_axi_tlst;
    logic [NCH-1:0]    ch_ram_rdy;
    logic [NCH-1:0]    ch_en;
    logic [IW-1:0]     cur_ch;
    logic              busy;
    logic              frame_done;
    logic              err_tlst;

    always #5 clk_dma = ~clk_dma;

    dma_tx_demux #(.NCH(NCH), .DW(DW), .BURST_LEN(BL)) dut (
        .clk_dma        (clk_dma),
        .srstn          (srstn),
        .s_axi_dma_trdy (s_axi_dma_trdy),
        .s_axi_dma_tvld (s_axi_dma_tvld),
        .s_axi_dma_tdat (s_axi_dma_tdat),
        .s_axi_dma_tlst (s_axi_dma_tlst),
        .m_axi_trdy     (m_axi_trdy),
        .m_axi_tvld     (m_axi_tvld),
        .m_axi_tdat     (m_axi_tdat),
        .m_axi_tlst     (m_axi_tlst),
        .ch_ram_rdy     (ch_ram_rdy),
        .ch_en          (ch_en),
        .cur_ch         (cur_ch),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_tlst       (err_tlst)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic          tlst;
        int            cur;
        int            cyc;
    } beat_t;

    beat_t          obs_q[$];
    logic [DW-1:0]  src_data[$];
    logic           src_last[$];
    int             src_idx;
    bit             hs_seen;
    int             mon_cycle;
    int             done_cnt;
    int             err_cnt;
    logic [NCH-1:0] tvld_seen;
    bit             rnd_vld;
    bit             rnd_ram;
    logic [NCH-1:0] trdy_rand_mask;
    int             exp_err;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observes the interface at the falling edge, where inputs and outputs are stable.
    always @(negedge clk_dma) begin
        hs_seen = srstn && s_axi_dma_tvld && s_axi_dma_trdy;
        if (srstn) begin
            mon_cycle++;
            for (int i = 0; i < NCH; i++) begin
                if (m_axi_tvld[i] && m_axi_trdy[i]) begin
                    beat_t b;
                    b.ch   = i;
                    b.data = m_axi_tdat[i*DW +: DW];
                    b.tlst = m_axi_tlst[i];
                    b.cur  = int'(cur_ch);
                    b.cyc  = mon_cycle;
                    obs_q.push_back(b);
                end
            end
            tvld_seen = tvld_seen | m_axi_tvld;
            if (frame_done) done_cnt++;
            if (err_tlst) err_cnt++;
            if (m_axi_tvld != '0 || s_axi_dma_trdy) begin
                check("hs_match", 64'(s_axi_dma_tvld && s_axi_dma_trdy),
                      64'(|(m_axi_tvld & m_axi_trdy)));
                check("tvld_onehot", 64'($countones(m_axi_tvld) <= 1), 64'(1));
            end
        end
    end

    // One clock: drive inputs just after the rising edge, return just after the falling edge.
    task automatic step();
        @(posedge clk_dma);
        #1;
        if (hs_seen) src_idx++;
        s_axi_dma_tvld = (src_idx < src_data.size()) && (!rnd_vld || $urandom_range(3) != 0);
        s_axi_dma_tdat = (src_idx < src_data.size()) ? src_data[src_idx] : '0;
        s_axi_dma_tlst = (src_idx < src_data.size()) ? src_last[src_idx] : 1'b0;
        m_axi_trdy     = ~(trdy_rand_mask & NCH'($urandom));
        if (rnd_ram) ch_ram_rdy = NCH'($urandom);
        @(negedge clk_dma);
        #1;
    endtask

    task automatic start_frame(input logic [NCH-1:0] mask, input int bad_idx, input bit rnd);
        int n;
        n = $countones(mask) * BL;
        src_data.delete();
        src_last.delete();
        src_idx = 0;
        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            logic l;
            l = (i == n - 1);
            if (rnd && $urandom_range(7) == 0) l = ~l;
            if (i == bad_idx) l = ~l;
            if (l != (i == n - 1)) exp_err++;
            src_data.push_back(rnd ? DW'($urandom) : DW'(i));
            src_last.push_back(l);
        end
        obs_q.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        tvld_seen = '0;
        ch_en = mask;
        step();
        ch_en = '0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 4000;
        while (done_cnt == 0 && budget > 0) begin
            step();
            budget--;
        end
        check("frame_timeout", 64'(budget > 0), 64'(1));
        step();
        step();
    endtask

    task automatic check_frame(input logic [NCH-1:0] mask);
        int n;
        int exp_ch[$];
        n = $countones(mask) * BL;
        for (int c = 0; c < NCH; c++)
            if (mask[c])
                for (int b = 0; b < BL; b++) exp_ch.push_back(c);
        check("beat_count", 64'(obs_q.size()), 64'(n));
        check("src_consumed", 64'(src_idx), 64'(n));
        for (int k = 0; k < n && k < obs_q.size(); k++) begin
            check("route_ch", 64'(obs_q[k].ch), 64'(exp_ch[k]));
            check("route_data", 64'(obs_q[k].data), 64'(src_data[k]));
            check("burst_tlst", 64'(obs_q[k].tlst), 64'(k % BL == BL - 1));
            check("cur_ch", 64'(obs_q[k].cur), 64'(exp_ch[k]));
            if (k > 0 && obs_q[k].ch != obs_q[k-1].ch)
                check("burst_bubble", 64'(obs_q[k].cyc - obs_q[k-1].cyc >= 2), 64'(1));
        end
        check("frame_done_cnt", 64'(done_cnt), 64'(1));
        check("err_tlst_cnt", 64'(err_cnt), 64'(exp_err));
        check("tvld_seen", 64'(tvld_seen), 64'(mask));
        check("idle_after", 64'(busy), 64'(0));
    endtask

    initial begin
        int budget;
        n_checks = 0;
        n_fail = 0;
        mon_cycle = 0;
        src_idx = 0;
        hs_seen = 1'b0;
        rnd_vld = 1'b0;
        rnd_ram = 1'b0;
        trdy_rand_mask = '0;
        s_axi_dma_tvld = 1'b0;
        s_axi_dma_tdat = '0;
        s_axi_dma_tlst = 1'b0;
        m_axi_trdy = '1;
        ch_ram_rdy = '0;
        ch_en = '0;
        srstn = 1'b0;
        repeat (3) step();
        srstn = 1'b1;

        check("rst_tvld", 64'(m_axi_tvld), 64'(0));
        check("rst_trdy", 64'(s_axi_dma_trdy), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cur_ch", 64'(cur_ch), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_err_tlst", 64'(err_tlst), 64'(0));

        // Full mask, free-flowing: 16 beats plus exactly three one-cycle bubbles.
        start_frame(4'b1111, -1, 1'b0);
        wait_done();
        check_frame(4'b1111);
        if (obs_q.size() == 16)
            check("full_frame_span", 64'(obs_q[15].cyc - obs_q[0].cyc), 64'(18));

        // Sparse mask: only channels 1 and 3.
        start_frame(4'b1010, -1, 1'b0);
        wait_done();
        check_frame(4'b1010);

        // Channel 2 buffer busy: demux parks in front of the ch2 burst.
        ch_ram_rdy = 4'b0100;
        start_frame(4'b1111, -1, 1'b0);
        budget = 500;
        while (obs_q.size() < 8 && budget > 0) begin
            step();
            budget--;
        end
        check("stall_reach_ch2", 64'(budget > 0), 64'(1));
        step();
        for (int i = 0; i < 20; i++) begin
            check("stall_trdy", 64'(s_axi_dma_trdy), 64'(0));
            check("stall_busy", 64'(busy), 64'(1));
            check("stall_tvld", 64'(m_axi_tvld), 64'(0));
            step();
        end
        ch_ram_rdy = '0;
        step();
        check("stall_release_tvld", 64'(m_axi_tvld), 64'(4'b0100));
        check("stall_release_cur", 64'(cur_ch), 64'(2));
        wait_done();
        check_frame(4'b1111);

        // Channel 1 ready toggles randomly.
        trdy_rand_mask = 4'b0010;
        start_frame(4'b1111, -1, 1'b0);
        wait_done();
        check_frame(4'b1111);
        trdy_rand_mask = '0;

        // Premature tlast on beat 6 of 16.
        start_frame(4'b1111, 5, 1'b0);
        wait_done();
        check_frame(4'b1111);

        // Reset in the middle of the ch1 burst, then a fresh frame.
        start_frame(4'b1111, -1, 1'b0);
        budget = 500;
        while (obs_q.size() < 6 && budget > 0) begin
            step();
            budget--;
        end
        check("reset_reach_ch1", 64'(budget > 0), 64'(1));
        srstn = 1'b0;
        step();
        srstn = 1'b1;
        check("midrst_tvld", 64'(m_axi_tvld), 64'(0));
        check("midrst_trdy", 64'(s_axi_dma_trdy), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        src_data.delete();
        src_last.delete();
        src_idx = 0;
        start_frame(4'b1111, -1, 1'b0);
        wait_done();
        check_frame(4'b1111);

        // Random frames: random masks, data, tlast errors, valid gaps, readies and buffer stalls.
        rnd_vld = 1'b1;
        rnd_ram = 1'b1;
        trdy_rand_mask = '1;
        for (int f = 0; f < 25; f++) begin
            logic [NCH-1:0] m;
            m = NCH'($urandom_range(15, 1));
            start_frame(m, -1, 1'b1);
            wait_done();
            check_frame(m);
        end
        rnd_vld = 1'b0;
        rnd_ram = 1'b0;
        trdy_rand_mask = '0;
        ch_ram_rdy = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
